// File: rtl/vram_pkg.sv
// vram_pkg: shared defaults and per-bank port-select type for the banked VRAM
package vram_pkg;
    localparam int DATA_WIDTH_DEF   = 16;
    localparam int LANE_WIDTH_DEF   = 4;
    localparam int BANK_COUNT_DEF   = 3;
    localparam int BANK_AW_DEF      = 14;
    localparam int STARVE_LIMIT_DEF = 4;
    typedef enum logic [1:0] {PORT_NONE, PORT_CPU, PORT_VID} port_sel_e;
endpackage

// File: rtl/vram_bank.sv
// vram_bank: one single-port lane-masked RAM bank with registered read data
module vram_bank #(
    parameter int DATA_WIDTH = 16,
    parameter int LANE_WIDTH = 4,
    parameter int BANK_AW    = 14,
    localparam int MASK_WIDTH = DATA_WIDTH / LANE_WIDTH
) (
    input  logic                  clk,
    input  logic                  en,
    input  logic                  we,
    input  logic [MASK_WIDTH-1:0] mask,
    input  logic [BANK_AW-1:0]    addr,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);
`ifdef SYNTHESIS
    if (DATA_WIDTH == 16 && LANE_WIDTH == 4 && BANK_AW == 14) begin : g_spram
        SB_SPRAM256KA u_spram (
            .ADDRESS(addr), .DATAIN(wdata), .MASKWREN(mask), .WREN(we),
            .CHIPSELECT(en), .CLOCK(clk), .STANDBY(1'b0), .SLEEP(1'b0),
            .POWEROFF(1'b1), .DATAOUT(rdata)
        );
    end else begin : g_model
        logic [DATA_WIDTH-1:0] mem [2**BANK_AW];
        always_ff @(posedge clk)
            if (en) begin
                for (int l = 0; l < MASK_WIDTH; l++)
                    if (we && mask[l]) mem[addr][l*LANE_WIDTH +: LANE_WIDTH] <= wdata[l*LANE_WIDTH +: LANE_WIDTH];
                if (!we) rdata <= mem[addr];
            end
    end
`else
    logic [DATA_WIDTH-1:0] mem [2**BANK_AW];
    always_ff @(posedge clk)
        if (en) begin
            for (int l = 0; l < MASK_WIDTH; l++)
                if (we && mask[l]) mem[addr][l*LANE_WIDTH +: LANE_WIDTH] <= wdata[l*LANE_WIDTH +: LANE_WIDTH];
            if (!we) rdata <= mem[addr];
        end
`endif
endmodule

// File: rtl/vram_banked.sv
// vram_banked: multi-bank VRAM with a CPU port and a video-priority scan-out port plus CPU anti-starvation
module vram_banked import vram_pkg::*; #(
    parameter int DATA_WIDTH   = DATA_WIDTH_DEF,
    parameter int LANE_WIDTH   = LANE_WIDTH_DEF,
    parameter int BANK_COUNT   = BANK_COUNT_DEF,
    parameter int BANK_AW      = BANK_AW_DEF,
    parameter int STARVE_LIMIT = STARVE_LIMIT_DEF,
    localparam int MASK_WIDTH  = DATA_WIDTH / LANE_WIDTH,
    localparam int BANK_W      = $clog2(BANK_COUNT),
    localparam int ADDR_WIDTH  = BANK_AW + BANK_W,
    localparam int CNT_W       = $clog2(STARVE_LIMIT + 1)
) (
    input  logic                  clk,
    input  logic                  reset_n_i,
    input  logic                  cpu_req_i,
    input  logic                  cpu_we_i,
    input  logic [MASK_WIDTH-1:0] cpu_mask_i,
    input  logic [ADDR_WIDTH-1:0] cpu_addr_i,
    input  logic [DATA_WIDTH-1:0] cpu_wdata_i,
    output logic                  cpu_gnt_o,
    output logic                  cpu_rvalid_o,
    output logic [DATA_WIDTH-1:0] cpu_rdata_o,
    input  logic                  vid_req_i,
    input  logic [ADDR_WIDTH-1:0] vid_addr_i,
    output logic                  vid_gnt_o,
    output logic                  vid_rvalid_o,
    output logic [DATA_WIDTH-1:0] vid_rdata_o
);
    logic [BANK_W-1:0]     cpu_bank, vid_bank, cpu_bank_q, vid_bank_q;
    logic                  cpu_oor, vid_oor, cpu_win, vid_win, force_cpu;
    logic                  cpu_rvalid_q, vid_rvalid_q;
    logic [CNT_W-1:0]      stall_q;
    logic [DATA_WIDTH-1:0] cpu_mux, vid_mux, cpu_hold_q, vid_hold_q;
    port_sel_e             sel [BANK_COUNT];
    logic [DATA_WIDTH-1:0] bank_rdata [BANK_COUNT];
    assign cpu_bank  = cpu_addr_i[ADDR_WIDTH-1 -: BANK_W];
    assign vid_bank  = vid_addr_i[ADDR_WIDTH-1 -: BANK_W];
    assign cpu_oor   = int'(cpu_bank) >= BANK_COUNT;
    assign vid_oor   = int'(vid_bank) >= BANK_COUNT;
    assign force_cpu = stall_q == CNT_W'(STARVE_LIMIT);
    for (genvar b = 0; b < BANK_COUNT; b++) begin : g_bank
        logic cpu_hit, vid_hit;
        assign cpu_hit = cpu_req_i && cpu_bank == BANK_W'(b);
        assign vid_hit = vid_req_i && vid_bank == BANK_W'(b);
        assign sel[b]  = !reset_n_i ? PORT_NONE :
                         vid_hit && !(cpu_hit && force_cpu) ? PORT_VID :
                         cpu_hit ? PORT_CPU : PORT_NONE;
        vram_bank #(.DATA_WIDTH(DATA_WIDTH), .LANE_WIDTH(LANE_WIDTH), .BANK_AW(BANK_AW)) u_bank (
            .clk   (clk),
            .en    (sel[b] != PORT_NONE),
            .we    (sel[b] == PORT_CPU && cpu_we_i),
            .mask  (cpu_mask_i),
            .addr  (sel[b] == PORT_CPU ? cpu_addr_i[BANK_AW-1:0] : vid_addr_i[BANK_AW-1:0]),
            .wdata (cpu_wdata_i),
            .rdata (bank_rdata[b])
        );
    end
    always_comb begin
        cpu_win = 1'b0;
        vid_win = 1'b0;
        cpu_mux = '0;
        vid_mux = '0;
        for (int i = 0; i < BANK_COUNT; i++) begin
            cpu_win = cpu_win || sel[i] == PORT_CPU;
            vid_win = vid_win || sel[i] == PORT_VID;
            cpu_mux = int'(cpu_bank_q) == i ? bank_rdata[i] : cpu_mux;
            vid_mux = int'(vid_bank_q) == i ? bank_rdata[i] : vid_mux;
        end
    end
    assign cpu_gnt_o    = reset_n_i && cpu_req_i && (cpu_oor || cpu_win);
    assign vid_gnt_o    = reset_n_i && vid_req_i && (vid_oor || vid_win);
    assign cpu_rvalid_o = cpu_rvalid_q;
    assign vid_rvalid_o = vid_rvalid_q;
    assign cpu_rdata_o  = cpu_rvalid_q ? cpu_mux : cpu_hold_q;
    assign vid_rdata_o  = vid_rvalid_q ? vid_mux : vid_hold_q;
    always_ff @(posedge clk or negedge reset_n_i)
        if (!reset_n_i) begin
            cpu_rvalid_q <= 1'b0;
            vid_rvalid_q <= 1'b0;
            cpu_bank_q   <= '0;
            vid_bank_q   <= '0;
            cpu_hold_q   <= '0;
            vid_hold_q   <= '0;
            stall_q      <= '0;
        end else begin
            cpu_rvalid_q <= cpu_gnt_o && !cpu_we_i;
            vid_rvalid_q <= vid_gnt_o;
            if (cpu_gnt_o) cpu_bank_q <= cpu_bank;
            if (vid_gnt_o) vid_bank_q <= vid_bank;
            if (cpu_rvalid_q) cpu_hold_q <= cpu_mux;
            if (vid_rvalid_q) vid_hold_q <= vid_mux;
            stall_q <= !cpu_req_i || cpu_gnt_o ? '0 : force_cpu ? stall_q : stall_q + 1'b1;
        end
endmodule

// File: tb/tb_vram_banked.sv
// tb_vram_banked: directed and randomized checks of vram_banked against a word-level memory/arbitration model
module tb_vram_banked;
    logic        clk = 1'b0;
    logic        reset_n_i = 1'b1;
    logic        cpu_req_i = 1'b0, cpu_we_i = 1'b0;
    logic [3:0]  cpu_mask_i = '0;
    logic [15:0] cpu_addr_i = '0, cpu_wdata_i = '0;
    logic        cpu_gnt_o, cpu_rvalid_o;
    logic [15:0] cpu_rdata_o;
    logic        vid_req_i = 1'b0;
    logic [15:0] vid_addr_i = '0;
    logic        vid_gnt_o, vid_rvalid_o;
    logic [15:0] vid_rdata_o;
    int n_checks = 0, n_fail = 0;
    bit [15:0] mdl [int];

    vram_banked dut (
        .clk(clk), .reset_n_i(reset_n_i),
        .cpu_req_i(cpu_req_i), .cpu_we_i(cpu_we_i), .cpu_mask_i(cpu_mask_i),
        .cpu_addr_i(cpu_addr_i), .cpu_wdata_i(cpu_wdata_i),
        .cpu_gnt_o(cpu_gnt_o), .cpu_rvalid_o(cpu_rvalid_o), .cpu_rdata_o(cpu_rdata_o),
        .vid_req_i(vid_req_i), .vid_addr_i(vid_addr_i),
        .vid_gnt_o(vid_gnt_o), .vid_rvalid_o(vid_rvalid_o), .vid_rdata_o(vid_rdata_o)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mdl_read(input logic [15:0] a);
        if (a[15:14] == 2'd3) return 16'h0000;
        return mdl.exists(int'(a)) ? mdl[int'(a)] : 16'h0000;
    endfunction

    function automatic void mdl_write(input logic [15:0] a, input logic [15:0] d, input logic [3:0] m);
        logic [15:0] bm;
        logic [15:0] old;
        if (a[15:14] == 2'd3) return;
        bm  = {{4{m[3]}}, {4{m[2]}}, {4{m[1]}}, {4{m[0]}}};
        old = mdl.exists(int'(a)) ? mdl[int'(a)] : 16'h0000;
        mdl[int'(a)] = (old & ~bm) | (d & bm);
    endfunction

    function automatic logic [15:0] raddr();
        return {2'($urandom_range(0, 3)), 11'd0, 3'($urandom_range(0, 7))};
    endfunction

    task automatic cpu_drive(input logic req, input logic we, input logic [3:0] m, input logic [15:0] a, input logic [15:0] d);
        cpu_req_i = req; cpu_we_i = we; cpu_mask_i = m; cpu_addr_i = a; cpu_wdata_i = d;
    endtask

    task automatic vid_drive(input logic req, input logic [15:0] a);
        vid_req_i = req; vid_addr_i = a;
    endtask

    task automatic preload(input logic [15:0] a, input logic [15:0] d, input logic [3:0] m);
        @(negedge clk);
        cpu_drive(1'b1, 1'b1, m, a, d);
        vid_drive(1'b0, 16'h0);
        #1;
        n_checks++;
        if (cpu_gnt_o !== 1'b1) begin n_fail++; $display("FAIL preload_gnt addr %h: got %b expected 1", a, cpu_gnt_o); end
        mdl_write(a, d, m);
        @(posedge clk);
        #1 cpu_req_i = 1'b0;
    endtask

    task automatic test_reset;
        #2 reset_n_i = 1'b0;
        cpu_drive(1'b1, 1'b0, 4'hF, 16'h0000, 16'h0);
        vid_drive(1'b1, 16'h4000);
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if (cpu_gnt_o !== 1'b0 || vid_gnt_o !== 1'b0) begin n_fail++; $display("FAIL reset_gnt: got %b%b expected 00", cpu_gnt_o, vid_gnt_o); end
        n_checks++;
        if (cpu_rvalid_o !== 1'b0 || vid_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_rvalid: got %b%b expected 00", cpu_rvalid_o, vid_rvalid_o); end
        n_checks++;
        if (cpu_rdata_o !== 16'h0 || vid_rdata_o !== 16'h0) begin n_fail++; $display("FAIL reset_rdata: got %h %h expected 0000 0000", cpu_rdata_o, vid_rdata_o); end
        @(negedge clk);
        cpu_drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
        vid_drive(1'b0, 16'h0);
        reset_n_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid_o !== 1'b0 || vid_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL reset_release_rvalid: got %b%b expected 00", cpu_rvalid_o, vid_rvalid_o); end
    endtask

    task automatic test_write_read;
        @(negedge clk);
        cpu_drive(1'b1, 1'b1, 4'hF, 16'h0010, 16'hBEEF);
        #1;
        n_checks++;
        if (cpu_gnt_o !== 1'b1) begin n_fail++; $display("FAIL wr_gnt: got %b expected 1", cpu_gnt_o); end
        mdl_write(16'h0010, 16'hBEEF, 4'hF);
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL wr_no_rvalid: got %b expected 0", cpu_rvalid_o); end
        cpu_drive(1'b1, 1'b0, 4'h0, 16'h0010, 16'h0);
        #1;
        n_checks++;
        if (cpu_gnt_o !== 1'b1) begin n_fail++; $display("FAIL rd_gnt: got %b expected 1", cpu_gnt_o); end
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 16'hBEEF) begin n_fail++; $display("FAIL rd_data: got %b/%h expected 1/beef", cpu_rvalid_o, cpu_rdata_o); end
        cpu_drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid_o !== 1'b0 || cpu_rdata_o !== 16'hBEEF) begin n_fail++; $display("FAIL rd_hold: got %b/%h expected 0/beef", cpu_rvalid_o, cpu_rdata_o); end
    endtask

    task automatic test_mask;
        preload(16'h0020, 16'h1234, 4'hF);
        preload(16'h0020, 16'hABCD, 4'b0101);
        @(negedge clk);
        cpu_drive(1'b1, 1'b0, 4'h0, 16'h0020, 16'h0);
        @(negedge clk);
        cpu_drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
        n_checks++;
        if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 16'h1B3D) begin n_fail++; $display("FAIL mask_merge: got %b/%h expected 1/1b3d", cpu_rvalid_o, cpu_rdata_o); end
    endtask

    task automatic test_parallel;
        preload(16'h4000, 16'h5A5A, 4'hF);
        preload(16'h0000, 16'hA5A5, 4'hF);
        preload(16'h8000, 16'h3C3C, 4'hF);
        @(negedge clk);
        cpu_drive(1'b1, 1'b0, 4'h0, 16'h4000, 16'h0);
        vid_drive(1'b1, 16'h0000);
        #1;
        n_checks++;
        if (cpu_gnt_o !== 1'b1 || vid_gnt_o !== 1'b1) begin n_fail++; $display("FAIL par_gnt: got %b%b expected 11", cpu_gnt_o, vid_gnt_o); end
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 16'h5A5A) begin n_fail++; $display("FAIL par_cpu: got %b/%h expected 1/5a5a", cpu_rvalid_o, cpu_rdata_o); end
        n_checks++;
        if (vid_rvalid_o !== 1'b1 || vid_rdata_o !== 16'hA5A5) begin n_fail++; $display("FAIL par_vid: got %b/%h expected 1/a5a5", vid_rvalid_o, vid_rdata_o); end
        cpu_drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
        vid_drive(1'b0, 16'h0);
    endtask

    task automatic test_starve;
        int vk;
        logic pv, pc;
        logic [15:0] pexp;
        vk = 0; pv = 1'b0; pc = 1'b0; pexp = '0;
        preload(16'h0200, 16'h2222, 4'hF);
        for (int i = 0; i < 8; i++) preload(16'(16'h0100 + i), 16'(16'h1000 + i), 4'hF);
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            n_checks++;
            if (vid_rvalid_o !== pv || (pv && vid_rdata_o !== pexp)) begin n_fail++; $display("FAIL starve_vid_data c=%0d: got %b/%h expected %b/%h", c, vid_rvalid_o, vid_rdata_o, pv, pexp); end
            n_checks++;
            if (cpu_rvalid_o !== pc || (pc && cpu_rdata_o !== 16'h2222)) begin n_fail++; $display("FAIL starve_cpu_data c=%0d: got %b/%h expected %b/2222", c, cpu_rvalid_o, cpu_rdata_o, pc); end
            vid_drive(vk < 8, 16'(16'h0100 + vk));
            cpu_drive(c <= 4, 1'b0, 4'h0, 16'h0200, 16'h0);
            #1;
            n_checks++;
            if (cpu_gnt_o !== (c == 4)) begin n_fail++; $display("FAIL starve_cpu_gnt c=%0d: got %b expected %b", c, cpu_gnt_o, c == 4); end
            n_checks++;
            if (vid_gnt_o !== (vk < 8 && c != 4)) begin n_fail++; $display("FAIL starve_vid_gnt c=%0d: got %b expected %b", c, vid_gnt_o, vk < 8 && c != 4); end
            pv = vk < 8 && c != 4;
            pexp = 16'(16'h1000 + vk);
            pc = c == 4;
            if (pv) vk++;
        end
        @(negedge clk);
        n_checks++;
        if (vid_rvalid_o !== pv || (pv && vid_rdata_o !== pexp)) begin n_fail++; $display("FAIL starve_vid_last: got %b/%h expected %b/%h", vid_rvalid_o, vid_rdata_o, pv, pexp); end
        cpu_drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
        vid_drive(1'b0, 16'h0);
    endtask

    task automatic test_oor;
        preload(16'hC000, 16'hFFFF, 4'hF);
        @(negedge clk);
        cpu_drive(1'b1, 1'b0, 4'h0, 16'hC000, 16'h0);
        vid_drive(1'b1, 16'hC005);
        #1;
        n_checks++;
        if (cpu_gnt_o !== 1'b1 || vid_gnt_o !== 1'b1) begin n_fail++; $display("FAIL oor_gnt: got %b%b expected 11", cpu_gnt_o, vid_gnt_o); end
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 16'h0000) begin n_fail++; $display("FAIL oor_cpu_rdata: got %b/%h expected 1/0000", cpu_rvalid_o, cpu_rdata_o); end
        n_checks++;
        if (vid_rvalid_o !== 1'b1 || vid_rdata_o !== 16'h0000) begin n_fail++; $display("FAIL oor_vid_rdata: got %b/%h expected 1/0000", vid_rvalid_o, vid_rdata_o); end
        cpu_drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
        vid_drive(1'b0, 16'h0);
    endtask

    task automatic test_back_to_back;
        logic [15:0] e0, e1, e2, e3;
        e0 = 16'h0000; e1 = 16'h0000;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk);
            if (k > 0) begin
                n_checks++;
                if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== e0) begin n_fail++; $display("FAIL b2b_cpu k=%0d: got %b/%h expected 1/%h", k, cpu_rvalid_o, cpu_rdata_o, e0); end
                n_checks++;
                if (vid_rvalid_o !== 1'b1 || vid_rdata_o !== e1) begin n_fail++; $display("FAIL b2b_vid k=%0d: got %b/%h expected 1/%h", k, vid_rvalid_o, vid_rdata_o, e1); end
            end
            if (k == 8) break;
            e2 = 16'(16'h0100 + k);
            e3 = k[0] ? 16'h8000 : 16'h4000;
            cpu_drive(1'b1, 1'b0, 4'h0, e2, 16'h0);
            vid_drive(1'b1, e3);
            #1;
            n_checks++;
            if (cpu_gnt_o !== 1'b1 || vid_gnt_o !== 1'b1) begin n_fail++; $display("FAIL b2b_gnt k=%0d: got %b%b expected 11", k, cpu_gnt_o, vid_gnt_o); end
            e0 = mdl_read(e2);
            e1 = mdl_read(e3);
        end
        cpu_drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
        vid_drive(1'b0, 16'h0);
        n_checks++;
        if (mdl_read(16'h0000) !== 16'hA5A5 || mdl_read(16'h4000) !== 16'h5A5A || mdl_read(16'h8000) !== 16'h3C3C) begin
            n_fail++; $display("FAIL oor_model_untouched: got %h %h %h expected a5a5 5a5a 3c3c", mdl_read(16'h0000), mdl_read(16'h4000), mdl_read(16'h8000));
        end
    endtask

    task automatic test_oor_no_alias;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            cpu_drive(1'b1, 1'b0, 4'h0, {2'(k), 14'h0}, 16'h0);
            @(negedge clk);
            n_checks++;
            if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== (k == 0 ? 16'hA5A5 : k == 1 ? 16'h5A5A : 16'h3C3C)) begin
                n_fail++; $display("FAIL oor_no_alias bank=%0d: got %b/%h", k, cpu_rvalid_o, cpu_rdata_o);
            end
            cpu_drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
        end
    endtask

    task automatic test_reset_inflight;
        preload(16'h0030, 16'h7777, 4'hF);
        @(negedge clk);
        cpu_drive(1'b1, 1'b0, 4'h0, 16'h0030, 16'h0);
        vid_drive(1'b1, 16'h4000);
        #1;
        n_checks++;
        if (cpu_gnt_o !== 1'b1) begin n_fail++; $display("FAIL inflight_gnt: got %b expected 1", cpu_gnt_o); end
        @(posedge clk);
        #1 reset_n_i = 1'b0;
        #1;
        n_checks++;
        if (cpu_rvalid_o !== 1'b0 || vid_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL inflight_rvalid: got %b%b expected 00", cpu_rvalid_o, vid_rvalid_o); end
        n_checks++;
        if (cpu_rdata_o !== 16'h0 || vid_rdata_o !== 16'h0 || cpu_gnt_o !== 1'b0 || vid_gnt_o !== 1'b0) begin
            n_fail++; $display("FAIL inflight_outputs: got %h %h %b%b expected 0000 0000 00", cpu_rdata_o, vid_rdata_o, cpu_gnt_o, vid_gnt_o);
        end
        @(negedge clk);
        cpu_drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
        vid_drive(1'b0, 16'h0);
        @(negedge clk);
        reset_n_i = 1'b1;
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid_o !== 1'b0 || vid_rvalid_o !== 1'b0) begin n_fail++; $display("FAIL inflight_dropped: got %b%b expected 00", cpu_rvalid_o, vid_rvalid_o); end
        cpu_drive(1'b1, 1'b0, 4'h0, 16'h0030, 16'h0);
        @(negedge clk);
        n_checks++;
        if (cpu_rvalid_o !== 1'b1 || cpu_rdata_o !== 16'h7777) begin n_fail++; $display("FAIL inflight_mem_kept: got %b/%h expected 1/7777", cpu_rvalid_o, cpu_rdata_o); end
        cpu_drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
    endtask

    task automatic test_random;
        logic cp, cwe, vreq, conflict, egc, egv, exp_cv, exp_vv, hc, hv;
        logic [3:0]  cm;
        logic [15:0] ca, cd, va, exp_cd, exp_vd, last_c, last_v;
        int starve;
        cp = 0; cwe = 0; cm = '0; ca = '0; cd = '0; exp_cv = 0; exp_vv = 0; hc = 0; hv = 0;
        exp_cd = '0; exp_vd = '0; last_c = '0; last_v = '0; starve = 0;
        for (int b = 0; b < 3; b++)
            for (int w = 0; w < 8; w++) preload({2'(b), 11'd0, 3'(w)}, 16'($urandom), 4'hF);
        for (int n = 0; n <= 300; n++) begin
            @(negedge clk);
            n_checks++;
            if (cpu_rvalid_o !== exp_cv || (exp_cv && cpu_rdata_o !== exp_cd) || (!exp_cv && hc && cpu_rdata_o !== last_c)) begin
                n_fail++; $display("FAIL rnd_cpu_rdata n=%0d: got %b/%h expected %b/%h", n, cpu_rvalid_o, cpu_rdata_o, exp_cv, exp_cv ? exp_cd : last_c);
            end
            n_checks++;
            if (vid_rvalid_o !== exp_vv || (exp_vv && vid_rdata_o !== exp_vd) || (!exp_vv && hv && vid_rdata_o !== last_v)) begin
                n_fail++; $display("FAIL rnd_vid_rdata n=%0d: got %b/%h expected %b/%h", n, vid_rvalid_o, vid_rdata_o, exp_vv, exp_vv ? exp_vd : last_v);
            end
            if (exp_cv) begin last_c = exp_cd; hc = 1; end
            if (exp_vv) begin last_v = exp_vd; hv = 1; end
            if (n == 300) break;
            if (!cp && $urandom_range(0, 1) == 1) begin
                cp = 1; cwe = 1'($urandom_range(0, 1)); cm = 4'($urandom); ca = raddr(); cd = 16'($urandom);
            end
            vreq = $urandom_range(0, 2) != 0;
            va = raddr();
            cpu_drive(cp, cwe, cm, ca, cd);
            vid_drive(vreq, va);
            #1;
            conflict = cp && vreq && ca[15:14] == va[15:14] && ca[15:14] != 2'd3;
            egc = cp && (!conflict || starve == 4);
            egv = vreq && !(conflict && starve == 4);
            n_checks++;
            if (cpu_gnt_o !== egc || vid_gnt_o !== egv) begin
                n_fail++; $display("FAIL rnd_gnt n=%0d: got %b%b expected %b%b", n, cpu_gnt_o, vid_gnt_o, egc, egv);
            end
            exp_cv = egc && !cwe;
            exp_cd = mdl_read(ca);
            exp_vv = egv;
            exp_vd = mdl_read(va);
            if (egc && cwe) mdl_write(ca, cd, cm);
            starve = cp && !egc ? (starve < 4 ? starve + 1 : 4) : 0;
            if (egc) cp = 0;
        end
        cpu_drive(1'b0, 1'b0, 4'h0, 16'h0, 16'h0);
        vid_drive(1'b0, 16'h0);
    endtask

    initial begin
        test_reset;
        test_write_read;
        test_mask;
        test_parallel;
        test_starve;
        test_oor;
        test_back_to_back;
        test_oor_no_alias;
        test_reset_inflight;
        test_random;
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within 500000 time units");
        $fatal(1);
    end
endmodule
